conv_ctrl: RTL
==============

Name: conv_ctrl

Overview:
- Control unit for the 1-D convolution layer (N-sample input vector, M-tap filter, P=1 MAC).
- Sequences three parts: the input-vector memory (synchronous, 1-cycle read), the filter ROM (synchronous, 1-cycle read), and the multiply-accumulate datapath.
- Accepts N samples over a valid/ready input stream, then produces N-M+1 outputs one at a time over a valid/ready output stream, then returns to loading.
- Sits between the stream interfaces and the memory/MAC datapath inside the conv layer top.

Parameters:
N  64  input vector length (samples per vector)
M  8   filter taps; 2 <= M <= N
AW  $clog2(N)  input memory address width (derived)
FW  $clog2(M)  filter ROM address width (derived)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
x_valid  input  1  input sample valid
x_ready  output  1  controller can accept a sample
wr_en_x  output  1  write strobe to input memory
addr_x  output  AW  input memory address (write in LOAD, read in COMPUTE)
addr_f  output  FW  filter ROM read address
clear_acc  output  1  accumulator cleared at this clock edge
en_acc  output  1  acc += mem_x_data*rom_f_data at this clock edge
y_valid  output  1  accumulator holds a finished output
y_ready  input  1  downstream accepts the output
vec_done  output  1  1-cycle pulse on the last output handshake of a vector

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset (any state, any cycle, including mid-load and mid-compute):
  - state <= LOAD; write counter, k and m <= 0.
  - en_acc, y_valid and vec_done <= 0.
  - x_ready = 0 while reset is high.
  - Partial vector discarded; the next accepted sample is written to address 0.
- States: LOAD, COMPUTE, DRAIN, OUT.
- LOAD:
  - x_ready = 1; wr_en_x = x_valid & x_ready; addr_x = write counter.
  - Write counter increments on each handshake.
  - On the handshake with counter == N-1: counter <= 0, k <= 0, m <= 0, go to COMPUTE. x_ready is 0 in the next cycle.
- COMPUTE (M cycles):
  - addr_x = k+m; addr_f = m. No overflow, since k+m <= N-1.
  - clear_acc = 1 only when m == 0.
  - m increments each cycle; at m == M-1 go to DRAIN with m <= 0.
- en_acc is a register loaded each cycle with (state == COMPUTE). It is therefore high exactly M cycles, lagging the addresses by one cycle to match the memory read latency.
- DRAIN (1 cycle): en_acc = 1 for the last tap. addr_x/addr_f are don't-care and are held. Go to OUT.
- OUT:
  - y_valid = 1; en_acc = 0; clear_acc = 0. The accumulator holds its value.
  - On y_valid & y_ready:
    - If k == N-M: assert vec_done (registered, 1 cycle), go to LOAD with write counter 0.
    - Otherwise k <= k+1 and go to COMPUTE.
  - y_valid holds indefinitely while y_ready = 0.
  - y_valid falls in the cycle after the handshake.
- Datapath contract: clear_acc and en_acc are never high in the same cycle. clear_acc takes priority if misdriven.
- Throughput:
  - M+2 cycles per output minimum.
  - Load takes N cycles minimum.
  - No overlap between loading and computing.
- x_valid is ignored outside LOAD; y_ready is ignored outside OUT.

Test Plan:
- Reset check: reset high 2 cycles -> x_ready=0, y_valid=0, en_acc=0, clear_acc=0 during reset. x_ready=1 in the first cycle after reset falls.
- Full-rate load: x_valid=1 for 64 cycles -> wr_en_x high 64 cycles, addr_x 0..63. x_ready=0 on cycle 65; the first COMPUTE cycle shows addr_x=0, addr_f=0, clear_acc=1.
- First-output timing: COMPUTE starts at cycle t -> addr_x 0..7 and addr_f 0..7 at t..t+7. en_acc=1 exactly at t+1..t+8. y_valid=1 at t+9. With y_ready=1, the next clear_acc occurs at t+10 with addr_x=1.
- Backpressure: hold y_ready=0 for 20 cycles during OUT -> y_valid stays 1; en_acc, clear_acc and wr_en_x stay 0. The handshake on cycle 21 advances to k+1.
- Vector wrap with random x_valid/y_ready (50%) over 3 vectors -> exactly 57 y handshakes per vector. The last output reads addr_x 56..63. vec_done pulses once per vector, and the next load writes address 0. With a reference MAC model in the bench, all 171 outputs match.
- Reset mid-operation: assert reset during COMPUTE at k=20, m=3 -> next cycle in LOAD with x_ready=1, y_valid=0. A full new vector yields 57 correct outputs.

Source files
------------

// File: rtl/conv_ctrl.sv
// conv_ctrl - control unit for a 1-D convolution layer (P=1 MAC).
//
// Loads an N-sample vector over a valid/ready input stream into the input
// memory, then, for each output index k = 0 .. N-M, walks the M filter taps
// through the input memory and filter ROM (both 1-cycle synchronous reads)
// while driving the accumulator clear/enable strobes.  Each finished sum is
// offered on a valid/ready output stream.  After the last output of a vector
// the controller returns to loading.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   x_valid    input sample valid
//   x_ready    controller can accept a sample (LOAD only, low during reset)
//   wr_en_x    input memory write strobe (x_valid & x_ready)
//   addr_x     input memory address: write pointer in LOAD, k+m in COMPUTE
//   addr_f     filter ROM read address (tap index m)
//   clear_acc  accumulator is cleared at this clock edge
//   en_acc     acc += mem_x_data * rom_f_data at this clock edge
//   y_valid    accumulator holds a finished output
//   y_ready    downstream accepts the output
//   vec_done   1-cycle pulse after the last output handshake of a vector
//
// state   | meaning
// --------+-----------------------------------------------------------
// LOAD    | accept N samples, write them to the input memory
// COMPUTE | issue M tap reads (addr_x = k+m, addr_f = m)
// DRAIN   | one extra cycle so the last tap's read data is accumulated
// OUT     | hold y_valid until downstream accepts the output

module conv_ctrl #(
  parameter  int N  = 64,
  parameter  int M  = 8,
  localparam int AW = $clog2(N),
  localparam int FW = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x_valid,
  output logic          x_ready,
  output logic          wr_en_x,
  output logic [AW-1:0] addr_x,
  output logic [FW-1:0] addr_f,
  output logic          clear_acc,
  output logic          en_acc,
  output logic          y_valid,
  input  logic          y_ready,
  output logic          vec_done
);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  localparam logic [AW-1:0] W_LAST = AW'(N - 1);
  localparam logic [AW-1:0] K_LAST = AW'(N - M);
  localparam logic [FW-1:0] M_LAST = FW'(M - 1);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] k;
  logic [FW-1:0] m;
  logic          en_acc_q;
  logic          vec_done_q;

  logic          load_hs;
  logic          out_hs;
  logic          w_last;
  logic          k_last;
  logic          m_last;

  assign w_last  = (wcnt == W_LAST);
  assign k_last  = (k == K_LAST);
  assign m_last  = (m == M_LAST);
  assign load_hs = wr_en_x;
  assign out_hs  = (state == S_OUT) && y_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LOAD;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD: begin
        if (load_hs && w_last) state_nx = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (m_last) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        state_nx = S_OUT;
      end
      S_OUT: begin
        if (out_hs) state_nx = k_last ? S_LOAD : S_COMPUTE;
      end
      default: state_nx = S_LOAD;
    endcase
  end

  // Output logic
  always_comb begin
    x_ready   = 1'b0;
    addr_x    = '0;
    addr_f    = '0;
    clear_acc = 1'b0;
    y_valid   = 1'b0;
    case (state)
      S_LOAD: begin
        x_ready = ~reset;
        addr_x  = wcnt;
      end
      S_COMPUTE: begin
        addr_x    = k + AW'(m);
        addr_f    = m;
        clear_acc = (m == '0);
      end
      S_DRAIN, S_OUT: begin
        // Keep presenting the last tap's addresses; the memories' outputs
        // are not consumed after DRAIN, so this only avoids needless toggling.
        addr_x  = k + AW'(M_LAST);
        addr_f  = M_LAST;
        y_valid = (state == S_OUT);
      end
      default: begin
        x_ready = 1'b0;
      end
    endcase
    wr_en_x = x_valid & x_ready;
  end

  // en_acc lags COMPUTE by one cycle to line up with the memory read latency,
  // which makes it cover taps 0..M-1 in COMPUTE(m=1..M-1) plus DRAIN.
  // clear_acc wins if both would ever be asserted together.
  assign en_acc   = en_acc_q & ~clear_acc;
  assign vec_done = vec_done_q;

  // Counters and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt       <= '0;
      k          <= '0;
      m          <= '0;
      en_acc_q   <= 1'b0;
      vec_done_q <= 1'b0;
    end else begin
      en_acc_q   <= (state == S_COMPUTE);
      vec_done_q <= out_hs && k_last;

      if (load_hs) begin
        if (w_last) begin
          wcnt <= '0;
          k    <= '0;
          m    <= '0;
        end else begin
          wcnt <= wcnt + AW'(1);
        end
      end

      if (state == S_COMPUTE) begin
        m <= m_last ? '0 : m + FW'(1);
      end

      if (out_hs) begin
        if (k_last) begin
          wcnt <= '0;
        end else begin
          k <= k + AW'(1);
        end
      end
    end
  end

endmodule
